// File: rtl/ctrl_branch_unit_pkg.sv
// Shared control package: branch opcode encodings and default PC width.
// Used by the decoder and the branch resolution logic.
package ctrl_branch_unit_pkg;

    localparam int PROG_CTR_WID_DEF = 10;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_JMP  = 3'd1,
        BR_JZ   = 3'd2,
        BR_JNZ  = 3'd3,
        BR_JC   = 3'd4,
        BR_JNC  = 3'd5,
        BR_CALL = 3'd6,
        BR_RET  = 3'd7
    } br_op_e;

    function automatic logic br_cond(
        input br_op_e op,
        input logic   zero,
        input logic   carry
    );
        logic res;
        res = 1'b0;
        unique case (op)
            BR_JMP, BR_CALL, BR_RET: res = 1'b1;
            BR_JZ:   res = zero;
            BR_JNZ:  res = !zero;
            BR_JC:   res = carry;
            BR_JNC:  res = !carry;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ctrl_branch_unit_ras.sv
// Circular return-address stack: when full, a push overwrites the oldest
// entry because the write pointer has wrapped onto it.
module ctrl_ras #(
    parameter int PROG_CTR_WID = 10,
    parameter int RAS_DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [PROG_CTR_WID-1:0] push_data,
    output logic [PROG_CTR_WID-1:0] top,
    output logic                    empty,
    output logic                    full
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [PROG_CTR_WID-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]           sp;
    logic [CW-1:0]           count;

    assign empty = (count == '0);
    assign full  = (count == CW'(RAS_DEPTH));
    assign top   = mem[sp - PW'(1)];

    always_ff @(posedge clk) begin
        if (reset) begin
            sp    <= '0;
            count <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[sp] <= push_data;
            sp      <= sp + PW'(1);
            if (!full) begin
                count <= count + CW'(1);
            end
        end else if (pop && !empty) begin
            sp    <= sp - PW'(1);
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/ctrl_branch_unit.sv
// Branch resolution in EX: condition evaluation, redirect, two-cycle
// flush shadow and return-address stack management.
module ctrl_branch_unit
    import ctrl_branch_unit_pkg::*;
#(
    parameter int PROG_CTR_WID = PROG_CTR_WID_DEF,
    parameter int RAS_DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PROG_CTR_WID-1:0] prog_ctr,
    input  logic [2:0]              br_op_ID,
    input  logic [PROG_CTR_WID-1:0] br_target_ID,
    input  logic                    flag_zero_EX,
    input  logic                    flag_carry_EX,
    output logic                    branch_taken_EX,
    output logic [PROG_CTR_WID-1:0] nxt_prog_ctr_EX,
    output logic                    flush_pipe,
    output logic                    ras_overflow,
    output logic                    ras_underflow
);

    logic [PROG_CTR_WID-1:0] pc_ID;
    logic [PROG_CTR_WID-1:0] pc_EX;
    logic [PROG_CTR_WID-1:0] tgt_EX;
    br_op_e                  op_EX;
    logic                    shadow_cnt;

    logic                    push;
    logic                    pop;
    logic [PROG_CTR_WID-1:0] ras_top;
    logic                    ras_empty;
    logic                    ras_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_ID      <= '0;
            pc_EX      <= '0;
            tgt_EX     <= '0;
            op_EX      <= BR_NONE;
            shadow_cnt <= 1'b0;
        end else begin
            pc_ID      <= prog_ctr;
            pc_EX      <= pc_ID;
            tgt_EX     <= br_target_ID;
            op_EX      <= flush_pipe ? BR_NONE : br_op_e'(br_op_ID);
            // one-deep shadow: loaded on taken, expires after one cycle
            shadow_cnt <= branch_taken_EX;
        end
    end

    assign branch_taken_EX =
        br_cond(op_EX, flag_zero_EX, flag_carry_EX) && !shadow_cnt;
    assign flush_pipe = branch_taken_EX || shadow_cnt;

    assign push = branch_taken_EX && (op_EX == BR_CALL);
    assign pop  = branch_taken_EX && (op_EX == BR_RET);

    always_comb begin
        nxt_prog_ctr_EX = '0;
        if (branch_taken_EX) begin
            if (op_EX == BR_RET) begin
                nxt_prog_ctr_EX = ras_empty ? '0 : ras_top;
            end else begin
                nxt_prog_ctr_EX = tgt_EX;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            if (push && ras_full) begin
                ras_overflow <= 1'b1;
            end
            if (pop && ras_empty) begin
                ras_underflow <= 1'b1;
            end
        end
    end

    ctrl_ras #(
        .PROG_CTR_WID (PROG_CTR_WID),
        .RAS_DEPTH    (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_EX + PROG_CTR_WID'(1)),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

endmodule

// File: tb/tb_ctrl_branch_unit.sv
// Directed bench for ctrl_branch_unit: conditions, shadow, RAS wrap,
// overflow/underflow and reset during a taken cycle.
module tb_ctrl_branch_unit;
    import ctrl_branch_unit_pkg::*;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] prog_ctr;
    logic [2:0]   br_op_ID;
    logic [W-1:0] br_target_ID;
    logic         flag_zero_EX;
    logic         flag_carry_EX;
    logic         branch_taken_EX;
    logic [W-1:0] nxt_prog_ctr_EX;
    logic         flush_pipe;
    logic         ras_overflow;
    logic         ras_underflow;

    int n_cmp = 0;
    int n_bad = 0;

    ctrl_branch_unit #(
        .PROG_CTR_WID (W),
        .RAS_DEPTH    (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .prog_ctr        (prog_ctr),
        .br_op_ID        (br_op_ID),
        .br_target_ID    (br_target_ID),
        .flag_zero_EX    (flag_zero_EX),
        .flag_carry_EX   (flag_carry_EX),
        .branch_taken_EX (branch_taken_EX),
        .nxt_prog_ctr_EX (nxt_prog_ctr_EX),
        .flush_pipe      (flush_pipe),
        .ras_overflow    (ras_overflow),
        .ras_underflow   (ras_underflow)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] T_OP [9] = '{
        BR_JZ, BR_JNZ, BR_JNZ, BR_JC, BR_JC,
        BR_JNC, BR_JNC, BR_JMP, BR_NONE
    };
    localparam logic T_Z [9] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
    localparam logic T_C [9] = '{0, 0, 0, 1, 0, 0, 1, 0, 1};
    localparam logic T_X [9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};

    task automatic step(input logic [W-1:0] pc, input logic [2:0] op,
                        input logic [W-1:0] tgt);
        prog_ctr     = pc;
        br_op_ID     = op;
        br_target_ID = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, BR_NONE, '0);
    endtask

    // leaves the instruction in EX with pc_EX = pc
    task automatic exec(input logic [W-1:0] pc, input logic [2:0] op,
                        input logic [W-1:0] tgt, input logic z,
                        input logic c);
        flag_zero_EX  = z;
        flag_carry_EX = c;
        step(pc, BR_NONE, '0);
        step(pc + W'(1), op, tgt);
        br_op_ID = BR_NONE;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flag_zero_EX = 1'b1;
        flag_carry_EX = 1'b1;
        step(10'h155, BR_JMP, 10'h2AA);
        step(10'h156, BR_JMP, 10'h2AA);
        n_cmp++; if (branch_taken_EX !== 1'b0) begin n_bad++;
            $display("FAIL rst_taken got %b want 0", branch_taken_EX); end
        n_cmp++; if (nxt_prog_ctr_EX !== 10'h000) begin n_bad++;
            $display("FAIL rst_nxt got %h want 000", nxt_prog_ctr_EX); end
        n_cmp++; if (flush_pipe !== 1'b0) begin n_bad++;
            $display("FAIL rst_flush got %b want 0", flush_pipe); end
        n_cmp++; if (ras_overflow !== 1'b0) begin n_bad++;
            $display("FAIL rst_ovf got %b want 0", ras_overflow); end
        n_cmp++; if (ras_underflow !== 1'b0) begin n_bad++;
            $display("FAIL rst_udf got %b want 0", ras_underflow); end
        reset = 1'b0;
        idle(1);
        n_cmp++; if (branch_taken_EX !== 1'b0 || flush_pipe !== 1'b0) begin
            n_bad++; $display("FAIL post_rst got t=%b f=%b want 0 0",
                branch_taken_EX, flush_pipe); end
    endtask

    task automatic test_jz();
        exec(10'h010, BR_JZ, 10'h055, 1'b1, 1'b0);
        n_cmp++; if (branch_taken_EX !== 1'b1) begin n_bad++;
            $display("FAIL jz_taken got %b want 1", branch_taken_EX); end
        n_cmp++; if (nxt_prog_ctr_EX !== 10'h055) begin n_bad++;
            $display("FAIL jz_nxt got %h want 055", nxt_prog_ctr_EX); end
        n_cmp++; if (flush_pipe !== 1'b1) begin n_bad++;
            $display("FAIL jz_flush0 got %b want 1", flush_pipe); end
        idle(1);
        n_cmp++; if (flush_pipe !== 1'b1 || branch_taken_EX !== 1'b0) begin
            n_bad++; $display("FAIL jz_flush1 got f=%b t=%b want 1 0",
                flush_pipe, branch_taken_EX); end
        idle(1);
        n_cmp++; if (flush_pipe !== 1'b0) begin n_bad++;
            $display("FAIL jz_flush2 got %b want 0", flush_pipe); end
    endtask

    task automatic test_cond_table();
        for (int i = 0; i < 9; i++) begin
            logic [W-1:0] tgt;
            logic [W-1:0] want;
            tgt = 10'h100 + W'(i);
            want = T_X[i] ? tgt : '0;
            exec(10'h020 + W'(i * 4), T_OP[i], tgt, T_Z[i], T_C[i]);
            n_cmp++; if (branch_taken_EX !== T_X[i]) begin n_bad++;
                $display("FAIL cond%0d_taken got %b want %b",
                    i, branch_taken_EX, T_X[i]); end
            n_cmp++; if (flush_pipe !== T_X[i]) begin n_bad++;
                $display("FAIL cond%0d_flush got %b want %b",
                    i, flush_pipe, T_X[i]); end
            n_cmp++; if (nxt_prog_ctr_EX !== want) begin n_bad++;
                $display("FAIL cond%0d_nxt got %h want %h",
                    i, nxt_prog_ctr_EX, want); end
            idle(2);
        end
    endtask

    task automatic test_stack_unchanged();
        do_reset();
        exec(10'h030, BR_CALL, 10'h0F0, 1'b0, 1'b0);
        n_cmp++; if (nxt_prog_ctr_EX !== 10'h0F0) begin n_bad++;
            $display("FAIL call_nxt got %h want 0F0", nxt_prog_ctr_EX); end
        idle(2);
        exec(10'h040, BR_JNZ, 10'h0AA, 1'b1, 1'b0);
        n_cmp++; if (branch_taken_EX !== 1'b0 || flush_pipe !== 1'b0) begin
            n_bad++; $display("FAIL jnz_nt got t=%b f=%b want 0 0",
                branch_taken_EX, flush_pipe); end
        idle(2);
        exec(10'h050, BR_RET, 10'h3C3, 1'b1, 1'b0);
        n_cmp++; if (nxt_prog_ctr_EX !== 10'h031) begin n_bad++;
            $display("FAIL ret_after_jnz got %h want 031", nxt_prog_ctr_EX); end
        idle(2);
        n_cmp++; if (ras_underflow !== 1'b0) begin n_bad++;
            $display("FAIL ret_after_jnz_udf got %b want 0", ras_underflow); end
    endtask

    task automatic test_wrap();
        do_reset();
        exec(10'h3FF, BR_CALL, 10'h100, 1'b0, 1'b0);
        n_cmp++; if (nxt_prog_ctr_EX !== 10'h100) begin n_bad++;
            $display("FAIL wrap_call got %h want 100", nxt_prog_ctr_EX); end
        idle(2);
        exec(10'h060, BR_RET, 10'h2A5, 1'b0, 1'b0);
        n_cmp++; if (branch_taken_EX !== 1'b1 || nxt_prog_ctr_EX !== 10'h000)
        begin n_bad++; $display("FAIL wrap_ret got t=%b nxt=%h want 1 000",
            branch_taken_EX, nxt_prog_ctr_EX); end
        idle(2);
        n_cmp++; if (ras_underflow !== 1'b0) begin n_bad++;
            $display("FAIL wrap_udf got %b want 0", ras_underflow); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            exec(W'(i), BR_CALL, 10'h200 + W'(i), 1'b0, 1'b0);
            idle(2);
            if (i == 4) begin
                n_cmp++; if (ras_overflow !== 1'b0) begin n_bad++;
                    $display("FAIL ovf_early got %b want 0", ras_overflow); end
            end
        end
        n_cmp++; if (ras_overflow !== 1'b1) begin n_bad++;
            $display("FAIL ovf_set got %b want 1", ras_overflow); end
        for (int k = 0; k < 4; k++) begin
            exec(10'h300 + W'(k), BR_RET, 10'h000, 1'b0, 1'b0);
            n_cmp++; if (nxt_prog_ctr_EX !== W'(6 - k)) begin n_bad++;
                $display("FAIL ovf_ret%0d got %h want %h",
                    k, nxt_prog_ctr_EX, W'(6 - k)); end
            idle(2);
        end
        n_cmp++; if (ras_overflow !== 1'b1 || ras_underflow !== 1'b0) begin
            n_bad++; $display("FAIL ovf_sticky got o=%b u=%b want 1 0",
                ras_overflow, ras_underflow); end
    endtask

    task automatic test_underflow();
        do_reset();
        exec(10'h070, BR_RET, 10'h155, 1'b0, 1'b0);
        n_cmp++; if (branch_taken_EX !== 1'b1 || nxt_prog_ctr_EX !== 10'h000)
        begin n_bad++; $display("FAIL udf_ret got t=%b nxt=%h want 1 000",
            branch_taken_EX, nxt_prog_ctr_EX); end
        idle(1);
        n_cmp++; if (ras_underflow !== 1'b1) begin n_bad++;
            $display("FAIL udf_set got %b want 1", ras_underflow); end
        idle(5);
        n_cmp++; if (ras_underflow !== 1'b1 || flush_pipe !== 1'b0) begin
            n_bad++; $display("FAIL udf_sticky got u=%b f=%b want 1 0",
                ras_underflow, flush_pipe); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        exec(10'h040, BR_CALL, 10'h100, 1'b0, 1'b0);
        n_cmp++; if (branch_taken_EX !== 1'b1) begin n_bad++;
            $display("FAIL b2b_first got %b want 1", branch_taken_EX); end
        step(10'h042, BR_JMP, 10'h1AB);
        br_op_ID = BR_NONE;
        n_cmp++; if (branch_taken_EX !== 1'b0 || flush_pipe !== 1'b1) begin
            n_bad++; $display("FAIL b2b_second got t=%b f=%b want 0 1",
                branch_taken_EX, flush_pipe); end
        idle(1);
        n_cmp++; if (branch_taken_EX !== 1'b0 || flush_pipe !== 1'b0) begin
            n_bad++; $display("FAIL b2b_after got t=%b f=%b want 0 0",
                branch_taken_EX, flush_pipe); end
        exec(10'h050, BR_RET, 10'h000, 1'b0, 1'b0);
        n_cmp++; if (nxt_prog_ctr_EX !== 10'h041) begin n_bad++;
            $display("FAIL b2b_ret got %h want 041", nxt_prog_ctr_EX); end
        idle(2);
        exec(10'h058, BR_RET, 10'h000, 1'b0, 1'b0);
        idle(1);
        n_cmp++; if (ras_underflow !== 1'b1) begin n_bad++;
            $display("FAIL b2b_single_push got %b want 1", ras_underflow); end
        idle(1);
    endtask

    task automatic test_reset_in_taken();
        exec(10'h080, BR_JMP, 10'h123, 1'b0, 1'b0);
        n_cmp++; if (nxt_prog_ctr_EX !== 10'h123) begin n_bad++;
            $display("FAIL rit_jmp got %h want 123", nxt_prog_ctr_EX); end
        reset = 1'b1;
        step(10'h082, BR_CALL, 10'h1FF);
        n_cmp++; if (branch_taken_EX !== 1'b0 || flush_pipe !== 1'b0 ||
                     nxt_prog_ctr_EX !== 10'h000) begin n_bad++;
            $display("FAIL rit_rst got t=%b f=%b nxt=%h want 0 0 000",
                branch_taken_EX, flush_pipe, nxt_prog_ctr_EX); end
        n_cmp++; if (ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
            n_bad++; $display("FAIL rit_sticky got o=%b u=%b want 0 0",
                ras_overflow, ras_underflow); end
        reset = 1'b0;
        idle(1);
        n_cmp++; if (branch_taken_EX !== 1'b0 || flush_pipe !== 1'b0) begin
            n_bad++; $display("FAIL rit_post got t=%b f=%b want 0 0",
                branch_taken_EX, flush_pipe); end
        exec(10'h090, BR_RET, 10'h0CC, 1'b0, 1'b0);
        n_cmp++; if (nxt_prog_ctr_EX !== 10'h000) begin n_bad++;
            $display("FAIL rit_ret got %h want 000", nxt_prog_ctr_EX); end
        idle(1);
        n_cmp++; if (ras_underflow !== 1'b1) begin n_bad++;
            $display("FAIL rit_empty got %b want 1", ras_underflow); end
    endtask

    initial begin
        reset = 1'b1;
        prog_ctr = '0;
        br_op_ID = BR_NONE;
        br_target_ID = '0;
        flag_zero_EX = 1'b0;
        flag_carry_EX = 1'b0;
        test_reset();
        test_jz();
        test_cond_table();
        test_stack_unchanged();
        test_wrap();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_reset_in_taken();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
            n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ctrl_branch_unit.md
CTRL_BRANCH_UNIT -- requirements
Module: ctrl_branch_unit

Interface
REQ-001 The block SHALL have parameter PROG_CTR_WID, default 10, program counter width in bits.
REQ-002 The block SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, at least 2).
REQ-003 The block SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1, reset; synchronous, active-high.
REQ-005 The block SHALL have port prog_ctr, input, PROG_CTR_WID, address of the instruction currently being fetched.
REQ-006 The block SHALL have port br_op_ID, input, 3, decoded branch opcode of the instruction in ID: 0 NONE, 1 JMP, 2 JZ, 3 JNZ, 4 JC, 5 JNC, 6 CALL, 7 RET.
REQ-007 The block SHALL have port br_target_ID, input, PROG_CTR_WID, absolute target decoded in ID; ignored for RET and NONE.
REQ-008 The block SHALL have port flag_zero_EX, input, 1, ALU zero flag valid in the EX cycle.
REQ-009 The block SHALL have port flag_carry_EX, input, 1, ALU carry flag valid in the EX cycle.
REQ-010 The block SHALL have port branch_taken_EX, output, 1, redirect request to the program counter.
REQ-011 The block SHALL have port nxt_prog_ctr_EX, output, PROG_CTR_WID, redirect address, meaningful only while branch_taken_EX=1.
REQ-012 The block SHALL have port flush_pipe, output, 1, squash the wrong-path instructions in ID and EX.
REQ-013 The block SHALL have port ras_overflow, output, 1, sticky: CALL issued with stack full.
REQ-014 The block SHALL have port ras_underflow, output, 1, sticky: RET issued with stack empty.

Function
REQ-015 The block SHALL register prog_ctr into pc_ID each cycle, so pc_ID is the address of the instruction in ID.
REQ-016 The block SHALL register pc_ID, br_op_ID and br_target_ID into pc_EX, op_EX and tgt_EX each cycle; op_EX SHALL load NONE while flush_pipe=1.
REQ-017 Condition SHALL be: JMP, CALL, RET always; JZ if flag_zero_EX=1; JNZ if flag_zero_EX=0; JC if flag_carry_EX=1; JNC if flag_carry_EX=0; NONE never.
REQ-018 branch_taken_EX SHALL be combinational from op_EX and flags in the same cycle (zero added latency); the program counter loads the redirect on the following edge.
REQ-019 nxt_prog_ctr_EX SHALL be tgt_EX for JMP/Jcc/CALL, the stack top for RET with a non-empty stack, and 0 for RET with an empty stack.
REQ-020 A taken CALL SHALL push (pc_EX + 1) mod 2^PROG_CTR_WID onto the stack at the end of the EX cycle.
REQ-021 A CALL with the stack full SHALL overwrite the oldest entry (circular), keep the count at RAS_DEPTH and set ras_overflow.
REQ-022 A RET SHALL pop one entry; a RET with the stack empty SHALL leave the count at 0, redirect to 0 and set ras_underflow.
REQ-023 flush_pipe SHALL be 1 in the cycle branch_taken_EX=1 and in the immediately following cycle (two-instruction shadow), via a shadow counter loaded with 1 on taken.
REQ-024 While flush_pipe=1, branch_taken_EX SHALL be 0 and the stack SHALL not change, regardless of op_EX or the flags.
REQ-025 Back-to-back branches SHALL resolve only the first; the second lies in the shadow and is discarded.
REQ-026 Sticky flags SHALL clear only on reset.

Reset
REQ-027 On reset, pc_ID, pc_EX and tgt_EX SHALL be 0, op_EX SHALL be NONE, the shadow counter 0, the stack count 0 and entries 0.
REQ-028 During and after reset, branch_taken_EX, nxt_prog_ctr_EX, flush_pipe, ras_overflow and ras_underflow SHALL read 0 until a branch resolves.
REQ-029 A reset asserted in a taken cycle SHALL override it: no push or pop, shadow cleared.

Structure
REQ-030 The opcode encodings (NONE..RET) and the default PROG_CTR_WID SHALL live in the shared control package used by the decoder and this block.
REQ-031 The return-address stack SHALL be a sub-module ctrl_ras (push, pop, top, empty, full, circular overwrite), parameterized by PROG_CTR_WID and RAS_DEPTH.

Verification
REQ-032 JZ at pc_EX=0x010, tgt=0x055, flag_zero_EX=1 -> branch_taken_EX=1, nxt_prog_ctr_EX=0x055, flush_pipe high for exactly 2 cycles.
REQ-033 JNZ with flag_zero_EX=1 -> branch_taken_EX=0, flush_pipe=0, stack unchanged.
REQ-034 CALL at pc_EX=0x3FF, tgt=0x100, then RET -> push value 0x000 (wrap), RET redirects to 0x000.
REQ-035 Five CALLs at pc 0x001..0x005 with RAS_DEPTH=4, then four RETs -> ras_overflow=1, RETs return 0x006, 0x005, 0x004, 0x003.
REQ-036 RET after reset -> nxt_prog_ctr_EX=0x000, ras_underflow=1 and it stays 1.
REQ-037 JMP followed in the next cycle by CALL, then reset asserted during the JMP taken cycle -> no redirect after reset, stack count 0, all outputs 0.
